eth_addr_ctx_regs: RTL

Multi-context successor to the single-address Ethernet register block. It holds `NUM_CTX` independent MAC/IPv4/UDP address contexts behind the shared register port. Software writes shadow registers and commits a context mask. Active values, which feed the Ethernet/CHDR adapter and dispatcher, are swapped atomically only at a packet boundary on the monitored RX stream, so no packet is ever classified against a half-updated address.

---
 rtl/eth_addr_ctx_regs.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_addr_ctx_regs.sv
// eth_addr_ctx_regs: NUM_CTX MAC/IPv4/UDP address contexts behind one register port.
// Software writes the shadow registers, then commits a context mask. The committed
// contexts are copied to the active outputs in one cycle, and only at a packet boundary
// on the snooped RX stream.
// Optional feature: define ETH_ADDR_COMMIT_TIMEOUT_EN to force the apply after
// COMMIT_TIMEOUT consecutive wait cycles. A forced apply is flagged in STATUS[16].
module eth_addr_ctx_regs #(
  parameter int          NUM_CTX        = 2,
  parameter int          REG_AWIDTH     = 14,
  parameter int          BASE           = 0,
  parameter int          CTX_STRIDE     = 'h20,
  parameter logic [47:0] DEFAULT_MAC    = 48'h00802f16c52f,
  parameter logic [31:0] DEFAULT_IP     = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [15:0] DEFAULT_UDP    = 16'd49153,
  parameter int          COMMIT_TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    reg_wr_req,
  input  logic [REG_AWIDTH-1:0]   reg_wr_addr,
  input  logic [31:0]             reg_wr_data,
  input  logic                    reg_rd_req,
  input  logic [REG_AWIDTH-1:0]   reg_rd_addr,
  output logic                    reg_rd_resp,
  output logic [31:0]             reg_rd_data,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tlast,
  output logic [48*NUM_CTX-1:0]   my_mac,
  output logic [32*NUM_CTX-1:0]   my_ip,
  output logic [16*NUM_CTX-1:0]   my_udp_port,
  output logic [NUM_CTX-1:0]      ctx_en,
  output logic                    cfg_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  localparam logic [REG_AWIDTH-1:0] OFF_COMMIT = REG_AWIDTH'('h1000);
  localparam logic [REG_AWIDTH-1:0] OFF_STATUS = REG_AWIDTH'('h1004);
  localparam logic [REG_AWIDTH-1:0] OFF_COUNT  = REG_AWIDTH'('h1008);

  // Offset of register r inside context c, relative to BASE
  function automatic logic [REG_AWIDTH-1:0] ctx_addr(input int c, input int r);
    return REG_AWIDTH'(c * CTX_STRIDE + r);
  endfunction

  logic [47:0] sh_mac_q  [NUM_CTX];
  logic [47:0] sh_mac_d  [NUM_CTX];
  logic [31:0] sh_ip_q   [NUM_CTX];
  logic [31:0] sh_ip_d   [NUM_CTX];
  logic [15:0] sh_udp_q  [NUM_CTX];
  logic [15:0] sh_udp_d  [NUM_CTX];
  logic [47:0] act_mac_q [NUM_CTX];
  logic [47:0] act_mac_d [NUM_CTX];
  logic [31:0] act_ip_q  [NUM_CTX];
  logic [31:0] act_ip_d  [NUM_CTX];
  logic [15:0] act_udp_q [NUM_CTX];
  logic [15:0] act_udp_d [NUM_CTX];
  logic [NUM_CTX-1:0] sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [NUM_CTX-1:0] pending_q, pending_d, applied, commit_mask;
  logic [15:0]        count_q, count_d;
  logic               in_pkt_q, in_pkt_d;
  logic               busy_q, busy_d;
  logic               rd_resp_q, rd_resp_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic [REG_AWIDTH-1:0] wr_off, rd_off;
  logic               hs, boundary, force_apply, apply, status_rd, timeout_flag;
  logic [1:0]         state;
  logic [7:0]         pend8;

  assign wr_off      = reg_wr_addr - REG_AWIDTH'(BASE);
  assign rd_off      = reg_rd_addr - REG_AWIDTH'(BASE);
  assign hs          = mon_tvalid & mon_tready;
  assign boundary    = !in_pkt_q && !hs;
  assign status_rd   = reg_rd_req && (rd_off == OFF_STATUS);
  assign commit_mask = (reg_wr_req && wr_off == OFF_COMMIT) ? reg_wr_data[NUM_CTX-1:0] : '0;

`ifdef ETH_ADDR_COMMIT_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;

  assign force_apply  = (pending_q != '0) && !boundary && (wait_cnt_q >= 16'(COMMIT_TIMEOUT));
  assign timeout_flag = timeout_q;

  // Wait-cycle counter and sticky timeout flag (a new timeout wins over a clearing read)
  always_comb begin
    wait_cnt_d = (state == ST_WAIT) ? wait_cnt_q + 16'd1 : 16'd0;
    timeout_d  = (timeout_q && !status_rd) || (apply && force_apply);
  end

  // Timeout state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`else
  assign force_apply  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Commit FSM: APPLY is the cycle in which pending contexts are copied to active
  always_comb begin
    if (pending_q == '0)               state = ST_IDLE;
    else if (boundary || force_apply)  state = ST_APPLY;
    else                               state = ST_WAIT;
    apply = (state == ST_APPLY);
  end

  // Shadow writes, shadow->active copy, pending/count bookkeeping and packet tracking
  always_comb begin
    sh_mac_d  = sh_mac_q;
    sh_ip_d   = sh_ip_q;
    sh_udp_d  = sh_udp_q;
    sh_en_d   = sh_en_q;
    act_mac_d = act_mac_q;
    act_ip_d  = act_ip_q;
    act_udp_d = act_udp_q;
    act_en_d  = act_en_q;
    count_d   = count_q;
    applied   = '0;
    // The copy reads the _q shadows, so a same-cycle shadow write is not applied yet
    if (apply) begin
      applied = pending_q;
      count_d = count_q + 16'd1;
      for (int c = 0; c < NUM_CTX; c++) begin
        if (pending_q[c]) begin
          act_mac_d[c] = sh_mac_q[c];
          act_ip_d[c]  = sh_ip_q[c];
          act_udp_d[c] = sh_udp_q[c];
          act_en_d[c]  = sh_en_q[c];
        end
      end
    end
    pending_d = (pending_q & ~applied) | commit_mask;
    busy_d    = |pending_d;
    if (reg_wr_req) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        if (wr_off == ctx_addr(c, 'h00)) sh_mac_d[c][31:0]  = reg_wr_data;
        if (wr_off == ctx_addr(c, 'h04)) sh_mac_d[c][47:32] = reg_wr_data[15:0];
        if (wr_off == ctx_addr(c, 'h08)) sh_ip_d[c]         = reg_wr_data;
        if (wr_off == ctx_addr(c, 'h0C)) sh_udp_d[c]        = reg_wr_data[15:0];
        if (wr_off == ctx_addr(c, 'h10)) sh_en_d[c]         = reg_wr_data[0];
      end
    end
    in_pkt_d = in_pkt_q;
    if (hs) in_pkt_d = !mon_tlast;
  end

  // Read decode: mapped addresses produce a response one cycle later
  always_comb begin
    pend8                = '0;
    pend8[NUM_CTX-1:0]   = pending_q;
    rd_resp_d            = 1'b0;
    rd_data_d            = rd_data_q;
    if (reg_rd_req) begin
      if (rd_off == OFF_STATUS) begin
        rd_resp_d = 1'b1;
        rd_data_d = {15'd0, timeout_flag, 8'd0, pend8};
      end else if (rd_off == OFF_COUNT) begin
        rd_resp_d = 1'b1;
        rd_data_d = {16'd0, count_q};
      end
      for (int c = 0; c < NUM_CTX; c++) begin
        if (rd_off == ctx_addr(c, 'h00)) begin
          rd_resp_d = 1'b1;
          rd_data_d = sh_mac_q[c][31:0];
        end
        if (rd_off == ctx_addr(c, 'h04)) begin
          rd_resp_d = 1'b1;
          rd_data_d = {16'd0, sh_mac_q[c][47:32]};
        end
        if (rd_off == ctx_addr(c, 'h08)) begin
          rd_resp_d = 1'b1;
          rd_data_d = sh_ip_q[c];
        end
        if (rd_off == ctx_addr(c, 'h0C)) begin
          rd_resp_d = 1'b1;
          rd_data_d = {16'd0, sh_udp_q[c]};
        end
        if (rd_off == ctx_addr(c, 'h10)) begin
          rd_resp_d = 1'b1;
          rd_data_d = {31'd0, sh_en_q[c]};
        end
      end
    end
  end

  // State registers; reset restores every context to its defaults
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        sh_mac_q[c]  <= DEFAULT_MAC;
        sh_ip_q[c]   <= DEFAULT_IP;
        sh_udp_q[c]  <= DEFAULT_UDP;
        act_mac_q[c] <= DEFAULT_MAC;
        act_ip_q[c]  <= DEFAULT_IP;
        act_udp_q[c] <= DEFAULT_UDP;
      end
      sh_en_q   <= NUM_CTX'(1);
      act_en_q  <= NUM_CTX'(1);
      pending_q <= '0;
      count_q   <= 16'd0;
      in_pkt_q  <= 1'b0;
      busy_q    <= 1'b0;
      rd_resp_q <= 1'b0;
      rd_data_q <= 32'd0;
    end else begin
      sh_mac_q  <= sh_mac_d;
      sh_ip_q   <= sh_ip_d;
      sh_udp_q  <= sh_udp_d;
      sh_en_q   <= sh_en_d;
      act_mac_q <= act_mac_d;
      act_ip_q  <= act_ip_d;
      act_udp_q <= act_udp_d;
      act_en_q  <= act_en_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      in_pkt_q  <= in_pkt_d;
      busy_q    <= busy_d;
      rd_resp_q <= rd_resp_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Flatten the active contexts onto the output buses
  always_comb begin
    my_mac      = '0;
    my_ip       = '0;
    my_udp_port = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      my_mac[c*48 +: 48]      = act_mac_q[c];
      my_ip[c*32 +: 32]       = act_ip_q[c];
      my_udp_port[c*16 +: 16] = act_udp_q[c];
    end
    ctx_en      = act_en_q;
    cfg_busy    = busy_q;
    reg_rd_resp = rd_resp_q;
    reg_rd_data = rd_data_q;
  end

endmodule
